// File: rtl/audio_sample_fifo.sv
// Stereo frame FIFO between packet decode and the I2S sender, with optional
// 2x frame replay for 22.05 kHz, host sample-request pacing and debug flags.
module audio_sample_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int REQ_LEVEL = 4
) (
  input  logic          mon_clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  input  logic          audio_starts,
  input  logic          end_audio_sample,
  input  logic          audio_22khz,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          request_mode,
  output logic          request_tick,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_REQ  = (AW+1)'(REQ_LEVEL);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t          state, state_next;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_next;
  logic            dup, dup_next;
  logic            req_pending, req_pending_next, tick_next;
  logic            flush, empty, full;
  logic            rd_fire, do_pop, do_write, ovf_set, unf_set;

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // NOTE: every variable in this block is assigned a default first so no latch is inferred.
  always_comb begin
    flush    = audio_starts;
    empty    = (level == '0);
    full     = (level == LVL_FULL);
    rd_fire  = rd_ready && !empty && !flush;
    do_pop   = rd_fire && (!audio_22khz || dup);
    do_write = wr_valid && !flush && (state != IDLE) && (!full || do_pop);
    ovf_set  = wr_valid && !flush && (state != IDLE) && full && !do_pop;
    unf_set  = rd_ready && empty && !flush && (state == RUN);

    dup_next = dup;
    if (flush)        dup_next = 1'b0;
    else if (rd_fire) dup_next = audio_22khz ? !dup : 1'b0;

    level_next = level;
    if (flush)                   level_next = '0;
    else if (do_write && !do_pop) level_next = level + LVL_ONE;
    else if (do_pop && !do_write) level_next = level - LVL_ONE;

    state_next = state;
    unique case (state)
      IDLE:    if (flush) state_next = RUN;
      RUN:     if (flush) state_next = RUN;
               else if (end_audio_sample) state_next = DRAIN;
      DRAIN:   if (flush) state_next = RUN;
               else if (empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A flush discards any outstanding request so a restart always ticks at once.
    tick_next = (state_next == RUN) && !(req_pending && !flush) && (level_next <= LVL_REQ);

    req_pending_next = req_pending;
    if (state_next != RUN)      req_pending_next = 1'b0;
    else if (tick_next)         req_pending_next = 1'b1;
    else if (flush || do_write) req_pending_next = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      dup          <= 1'b0;
      req_pending  <= 1'b0;
      request_mode <= 1'b0;
      request_tick <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state        <= state_next;
      level        <= level_next;
      dup          <= dup_next;
      req_pending  <= req_pending_next;
      request_mode <= (state_next == RUN);
      request_tick <= tick_next;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
        if (ovf_set)  overflow  <= 1'b1;
        if (unf_set)  underflow <= 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; a zero level hides stale contents behind rd_data = 0.
  always_ff @(posedge mon_clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a vector table for the streaming and
// replay paths, plus hand sequences for ticks, overflow, underflow, drain, reset.
module tb_audio_sample_fifo;

  logic        mon_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        audio_starts = 1'b0;
  logic        end_audio_sample = 1'b0;
  logic        audio_22khz = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        request_mode;
  logic        request_tick;
  logic [3:0]  level;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  always #5 mon_clk = ~mon_clk;

  audio_sample_fifo #(.DEPTH(8), .AW(3), .REQ_LEVEL(4)) dut (
    .mon_clk(mon_clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .audio_starts(audio_starts), .end_audio_sample(end_audio_sample),
    .audio_22khz(audio_22khz), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .request_mode(request_mode), .request_tick(request_tick),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        rd;
    logic        k22;
    logic [31:0] exp_data;
    logic [3:0]  exp_level;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and sample 1 time unit after the edge.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd,
                      input logic k22, input logic st, input logic en);
    wr_valid = wr; wr_data = d; rd_ready = rd; audio_22khz = k22;
    audio_starts = st; end_audio_sample = en;
    @(posedge mon_clk);
    #1;
    wr_valid = 1'b0; rd_ready = 1'b0; audio_starts = 1'b0; end_audio_sample = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] frame_x;
    frame_x = 32'hCAFE_0001;

    vecs[0] = '{1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 32'h1234_ABCD, 4'd1, 1'b1};
    vecs[1] = '{1'b1, 32'h8000_7FFF, 1'b0, 1'b0, 32'h1234_ABCD, 4'd2, 1'b1};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_7FFF, 4'd1, 1'b1};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 4'd0, 1'b0};
    vecs[4] = '{1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 32'hAAAA_5555, 4'd1, 1'b1};
    vecs[5] = '{1'b1, 32'h0001_FFFF, 1'b0, 1'b1, 32'hAAAA_5555, 4'd2, 1'b1};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hAAAA_5555, 4'd2, 1'b1};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0001_FFFF, 4'd1, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0001_FFFF, 4'd1, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 4'd0, 1'b0};

    // Reset values
    #12;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_request_mode", 32'(request_mode), 32'h0);
    check("rst_request_tick", 32'(request_tick), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_underflow", 32'(underflow), 32'h0);
    rst_n = 1'b1;
    @(posedge mon_clk); #1;

    // Start: mode and first tick together, then silence until a write
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("start_mode", 32'(request_mode), 32'h1);
    check("start_tick", 32'(request_tick), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("no_retick", 32'(request_tick), 32'h0);
    end
    step(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tick_on_write_edge", 32'(request_tick), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tick_after_write", 32'(request_tick), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_table_level", 32'(level), 32'h0);

    // Vector table: 44.1 kHz ordering and 22.05 kHz replay
    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].k22, 1'b0, 1'b0);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
    end
    check("table_overflow", 32'(overflow), 32'h0);
    check("table_underflow", 32'(underflow), 32'h0);

    // Fill to full, write+read while full, then a dropped 9th frame
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_level", 32'(level), 32'd8);
    check("full_no_overflow", 32'(overflow), 32'h0);
    step(1'b1, frame_x, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_rw_level", 32'(level), 32'd8);
    check("full_rw_overflow", 32'(overflow), 32'h0);
    step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("readback%0d", i), rd_data, (i == 7) ? frame_x : 32'h101 + 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("readback_level", 32'(level), 32'h0);
    check("readback_valid", 32'(rd_valid), 32'h0);

    // Underflow in RUN, cleared by restart
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unf_flag", 32'(underflow), 32'h1);
    check("unf_rd_data", rd_data, 32'h0);
    check("unf_level", 32'(level), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_underflow", 32'(underflow), 32'h0);
    check("restart_overflow", 32'(overflow), 32'h0);
    check("restart_tick", 32'(request_tick), 32'h1);

    // Drain three frames after end_audio_sample
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_start_level", 32'(level), 32'd3);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drain_mode", 32'(request_mode), 32'h0);
    check("drain_tick0", 32'(request_tick), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_data%0d", i), rd_data, 32'h200 + 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("drain_level%0d", i), 32'(level), 32'(2 - i));
      check($sformatf("drain_tick%0d", i + 1), 32'(request_tick), 32'h0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drain_empty_no_unf", 32'(underflow), 32'h0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_write_level", 32'(level), 32'h0);
    check("idle_write_valid", 32'(rd_valid), 32'h0);
    check("idle_mode", 32'(request_mode), 32'h0);

    // Asynchronous reset mid-stream
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h301, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'h0);
    check("async_rst_rd_data", rd_data, 32'h0);
    check("async_rst_valid", 32'(rd_valid), 32'h0);
    check("async_rst_mode", 32'(request_mode), 32'h0);
    #3 rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_level", 32'(level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
